// File: rtl/refclk_timebase.sv
// Timebase front end: synchronises the 32.768 kHz reference clock into i_clk,
// detects its rising edges and divides them into single-cycle strobes.
module refclk_timebase #(
  parameter int SYNC_STAGES   = 2,
  parameter int DIV_1HZ_BITS  = 15,
  parameter int SLOW_SET_BITS = 14,
  parameter int FAST_SET_BITS = 12,
  parameter int DEBOUNCE_BITS = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_refclk,
  output logic o_refclk_sync,
  output logic o_refclk_stb,
  output logic o_1hz_stb,
  output logic o_slow_set_stb,
  output logic o_fast_set_stb,
  output logic o_debounce_stb
);

  logic [SYNC_STAGES-1:0]  sync;
  logic                    prev;
  logic                    rise;
  logic [DIV_1HZ_BITS-1:0] cnt;

  assign o_refclk_sync = sync[SYNC_STAGES-1];

  // prev resets low so a refclk already high at release counts as an edge
  assign rise = o_refclk_sync & ~prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync           <= '0;
      prev           <= 1'b0;
      cnt            <= '0;
      o_refclk_stb   <= 1'b0;
      o_1hz_stb      <= 1'b0;
      o_slow_set_stb <= 1'b0;
      o_fast_set_stb <= 1'b0;
      o_debounce_stb <= 1'b0;
    end else begin
      sync           <= {sync[SYNC_STAGES-2:0], i_refclk};
      prev           <= o_refclk_sync;
      if (rise)
        cnt          <= cnt + 1'b1;
      o_refclk_stb   <= rise;
      o_1hz_stb      <= rise & (&cnt);
      o_slow_set_stb <= rise & (&cnt[SLOW_SET_BITS-1:0]);
      o_fast_set_stb <= rise & (&cnt[FAST_SET_BITS-1:0]);
      o_debounce_stb <= rise & (&cnt[DEBOUNCE_BITS-1:0]);
    end
  end

endmodule

// File: tb/tb_refclk_timebase.sv
// Scoreboard bench for refclk_timebase with a shortened divider chain so that
// several full 1 Hz wraps fit in a short run.
module tb_refclk_timebase;
  localparam int DIV  = 8;
  localparam int SLOW = 7;
  localparam int FAST = 5;
  localparam int DEB  = 3;

  logic clk = 1'b0, reset = 1'b1, refclk = 1'b0;
  logic refclk_sync, refclk_stb, hz_stb, slow_stb, fast_stb, deb_stb;

  always #50 clk = ~clk;

  refclk_timebase #(
    .SYNC_STAGES(2), .DIV_1HZ_BITS(DIV), .SLOW_SET_BITS(SLOW),
    .FAST_SET_BITS(FAST), .DEBOUNCE_BITS(DEB)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_refclk(refclk),
    .o_refclk_sync(refclk_sync), .o_refclk_stb(refclk_stb),
    .o_1hz_stb(hz_stb), .o_slow_set_stb(slow_stb),
    .o_fast_set_stb(fast_stb), .o_debounce_stb(deb_stb)
  );

  typedef struct {
    int         due;
    logic [4:0] mask;
  } sb_t;

  sb_t  sbq[$];
  int   n_run = 0, n_fail = 0, cyc = 0, ecount = 0, n_hz = 0;
  logic last_lvl = 1'b0, samp_d1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; a rising refclk sampled at posedge p must
  // produce its strobes in the cycle after posedge p+2.
  task automatic step(input logic rc, input logic rst);
    logic [4:0] em;
    logic       samp;
    refclk = rc;
    reset  = rst;
    @(posedge clk);
    cyc++;
    samp = rst ? 1'b0 : rc;
    if (rst) begin
      sbq.delete();
      ecount   = 0;
      last_lvl = 1'b0;
    end else begin
      if (rc && !last_lvl) begin
        ecount++;
        em = {1'b1,
              (ecount % (1 << DIV))  == 0,
              (ecount % (1 << SLOW)) == 0,
              (ecount % (1 << FAST)) == 0,
              (ecount % (1 << DEB))  == 0};
        sbq.push_back('{cyc + 2, em});
      end
      last_lvl = rc;
    end
    @(negedge clk);
    em = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) em = sbq.pop_front().mask;
    if (em[3]) n_hz++;
    chk("strobes", {27'd0, refclk_stb, hz_stb, slow_stb, fast_stb, deb_stb}, {27'd0, em});
    chk("sync", {31'd0, refclk_sync}, {31'd0, rst ? 1'b0 : samp_d1});
    samp_d1 = samp;
  endtask

  task automatic run_edges(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      int h, l;
      h = (hi > 0) ? hi : int'($urandom_range(2, 4));
      l = (lo > 0) ? lo : int'($urandom_range(2, 4));
      repeat (h) step(1'b1, 1'b0);
      repeat (l) step(1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset held with refclk toggling
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    // fastest refclk: one-cycle phases
    run_edges(20, 1, 1);
    // two full 1 Hz wraps and beyond
    run_edges(560, 0, 0);
    // reset mid-count with refclk toggling, release with refclk high
    run_edges(37, 2, 2);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    run_edges(300, 0, 0);
    // refclk frozen high, then frozen low: no strobes, count holds
    repeat (1000) step(1'b1, 1'b0);
    repeat (500) step(1'b0, 1'b0);
    run_edges(60, 2, 3);
    repeat (6) step(1'b0, 1'b0);
    chk("drain", sbq.size(), 0);
    chk("hz_count", n_hz, 3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
